// File: rtl/cotm32_priv_pkg.sv
// Privileged-architecture shared types: CLINT register map, mip view, trap causes.
// Imported by the CLINT and the CSR/trap logic.
package cotm32_priv_pkg;

    typedef enum logic [15:0] {
        CLINT_MSIP        = 16'h0000,
        CLINT_MTIMECMP_LO = 16'h4000,
        CLINT_MTIMECMP_HI = 16'h4004,
        CLINT_MTIME_LO    = 16'hBFF8,
        CLINT_MTIME_HI    = 16'hBFFC
    } clint_offset_t;

    typedef struct packed {
        logic [19:0] rsvd_31_12;
        logic        meip;
        logic        rsvd_10;
        logic        seip;
        logic        rsvd_8;
        logic        mtip;
        logic        rsvd_6;
        logic        stip;
        logic        rsvd_4;
        logic        msip;
        logic        rsvd_2;
        logic        ssip;
        logic        rsvd_0;
    } zicsr_val_mip_t;

    typedef enum logic [31:0] {
        TRAP_CAUSE_M_SOFTWARE_INTERRUPT = 32'h8000_0003,
        TRAP_CAUSE_M_TIMER_INTERRUPT    = 32'h8000_0007
    } trap_cause_t;

    localparam logic [63:0] CLINT_MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

    function automatic logic [31:0] be_merge(
        input logic [31:0] old_v,
        input logic [31:0] new_v,
        input logic [3:0]  be
    );
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[i*8 +: 8] = be[i] ? new_v[i*8 +: 8] : old_v[i*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/cotm32_clint_prescaler.sv
// mtime tick generator: one-cycle tick every PRESCALE_DIV clocks.
// PRESCALE_DIV=1 yields a tick on every cycle.
module cotm32_clint_prescaler #(
    parameter int unsigned PRESCALE_DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int unsigned CW =
        (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;
    localparam logic [CW-1:0] TERM = CW'(PRESCALE_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == TERM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/cotm32_clint.sv
// CLINT: mtime/mtimecmp/msip on the data bus, driving mip.mtip and mip.msip.
// Single-cycle registered bus response, no stalls.
module cotm32_clint
    import cotm32_priv_pkg::*;
#(
    parameter int unsigned PRESCALE_DIV = 1,
    parameter int unsigned ADDR_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  bus_req,
    input  logic                  bus_we,
    input  logic [ADDR_WIDTH-1:0] bus_addr,
    input  logic [3:0]            bus_be,
    input  logic [31:0]           bus_wdata,
    output logic                  bus_rvalid,
    output logic [31:0]           bus_rdata,
    output logic                  bus_err,
    output logic                  mtip,
    output logic                  msip
);

    logic        tick;
    logic [15:0] off;
    logic        addr_unused;

    logic [63:0] mtime_q;
    logic [63:0] mtimecmp_q;
    logic        msip_q;
    logic        mtip_q;
    logic        rvalid_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic        sel_msip;
    logic        sel_cmp_lo;
    logic        sel_cmp_hi;
    logic        sel_mt_lo;
    logic        sel_mt_hi;
    logic        mapped;
    logic        wr;
    logic [31:0] rd_val;

    logic [63:0] mtime_nxt;
    logic [63:0] mtimecmp_nxt;
    logic        msip_nxt;

    cotm32_clint_prescaler #(
        .PRESCALE_DIV(PRESCALE_DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (tick)
    );

    assign off         = 16'({bus_addr[ADDR_WIDTH-1:2], 2'b00});
    assign addr_unused = ^bus_addr[1:0];
    assign wr          = bus_req & bus_we;

    always_comb begin
        sel_msip   = 1'b0;
        sel_cmp_lo = 1'b0;
        sel_cmp_hi = 1'b0;
        sel_mt_lo  = 1'b0;
        sel_mt_hi  = 1'b0;
        mapped     = 1'b1;
        rd_val     = '0;
        case (off)
            CLINT_MSIP: begin
                sel_msip = 1'b1;
                rd_val   = {31'b0, msip_q};
            end
            CLINT_MTIMECMP_LO: begin
                sel_cmp_lo = 1'b1;
                rd_val     = mtimecmp_q[31:0];
            end
            CLINT_MTIMECMP_HI: begin
                sel_cmp_hi = 1'b1;
                rd_val     = mtimecmp_q[63:32];
            end
            CLINT_MTIME_LO: begin
                sel_mt_lo = 1'b1;
                rd_val    = mtime_q[31:0];
            end
            CLINT_MTIME_HI: begin
                sel_mt_hi = 1'b1;
                rd_val    = mtime_q[63:32];
            end
            default: mapped = 1'b0;
        endcase
    end

    // A write to either mtime half replaces that cycle's increment
    always_comb begin
        mtime_nxt = mtime_q + 64'(tick);
        if (wr && sel_mt_lo) begin
            mtime_nxt = {mtime_q[63:32],
                be_merge(mtime_q[31:0], bus_wdata, bus_be)};
        end else if (wr && sel_mt_hi) begin
            mtime_nxt = {be_merge(mtime_q[63:32], bus_wdata, bus_be),
                mtime_q[31:0]};
        end
    end

    always_comb begin
        mtimecmp_nxt = mtimecmp_q;
        if (wr && sel_cmp_lo) begin
            mtimecmp_nxt[31:0] =
                be_merge(mtimecmp_q[31:0], bus_wdata, bus_be);
        end
        if (wr && sel_cmp_hi) begin
            mtimecmp_nxt[63:32] =
                be_merge(mtimecmp_q[63:32], bus_wdata, bus_be);
        end
    end

    always_comb begin
        msip_nxt = msip_q;
        if (wr && sel_msip && bus_be[0]) begin
            msip_nxt = bus_wdata[0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mtime_q    <= '0;
            mtimecmp_q <= CLINT_MTIMECMP_RST;
            msip_q     <= 1'b0;
            mtip_q     <= 1'b0;
        end else begin
            mtime_q    <= mtime_nxt;
            mtimecmp_q <= mtimecmp_nxt;
            msip_q     <= msip_nxt;
            mtip_q     <= (mtime_nxt >= mtimecmp_nxt);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            rvalid_q <= bus_req;
            rdata_q  <= (bus_req && !bus_we && mapped) ? rd_val : '0;
            err_q    <= bus_req && !mapped;
        end
    end

    assign bus_rvalid = rvalid_q;
    assign bus_rdata  = rdata_q;
    assign bus_err    = err_q;
    assign mtip       = mtip_q;
    assign msip       = msip_q;

endmodule

// File: tb/tb_cotm32_clint.sv
// Directed bench for cotm32_clint: register table plus timer corner sequences.
// Two instances: PRESCALE_DIV=1 and PRESCALE_DIV=4 sharing one bus.
module tb_cotm32_clint;

    logic        clk;
    logic        rst_n;
    logic        bus_req;
    logic        bus_we;
    logic [15:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;

    logic        rvalid1, err1, mtip1, msip1;
    logic [31:0] rdata1;
    logic        rvalid4, err4, mtip4, msip4;
    logic [31:0] rdata4;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [15:0] A_MSIP = 16'h0000;
    localparam logic [15:0] A_CLO  = 16'h4000;
    localparam logic [15:0] A_CHI  = 16'h4004;
    localparam logic [15:0] A_TLO  = 16'hBFF8;
    localparam logic [15:0] A_THI  = 16'hBFFC;

    cotm32_clint #(.PRESCALE_DIV(1), .ADDR_WIDTH(16)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_be    (bus_be),
        .bus_wdata (bus_wdata),
        .bus_rvalid(rvalid1),
        .bus_rdata (rdata1),
        .bus_err   (err1),
        .mtip      (mtip1),
        .msip      (msip1)
    );

    cotm32_clint #(.PRESCALE_DIV(4), .ADDR_WIDTH(16)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_be    (bus_be),
        .bus_wdata (bus_wdata),
        .bus_rvalid(rvalid4),
        .bus_rdata (rdata4),
        .bus_err   (err4),
        .mtip      (mtip4),
        .msip      (msip4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [15:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic        exp_msip;
    } vec_t;

    vec_t vecs[23];

    function automatic vec_t mk(
        input logic req, input logic we, input logic [15:0] addr,
        input logic [3:0] be, input logic [31:0] wd,
        input logic [31:0] er, input logic ee, input logic em
    );
        vec_t v;
        v.req = req; v.we = we; v.addr = addr; v.be = be;
        v.wdata = wd; v.exp_rdata = er; v.exp_err = ee;
        v.exp_msip = em;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic req, input logic we,
                       input logic [15:0] addr, input logic [3:0] be,
                       input logic [31:0] wd);
        bus_req = req; bus_we = we; bus_addr = addr;
        bus_be = be; bus_wdata = wd;
        @(posedge clk);
        #1;
        bus_req = 1'b0; bus_we = 1'b0;
    endtask

    task automatic wr(input logic [15:0] a, input logic [3:0] be,
                      input logic [31:0] wd);
        cyc(1'b1, 1'b1, a, be, wd);
    endtask

    task automatic rd(input logic [15:0] a);
        cyc(1'b1, 1'b0, a, 4'h0, 32'h0);
    endtask

    logic [31:0] vals[40];

    initial begin
        rst_n = 1'b0;
        bus_req = 1'b0; bus_we = 1'b0; bus_addr = '0;
        bus_be = '0; bus_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rvalid", rvalid1, 0);
        chk("rst_rdata", rdata1, 0);
        chk("rst_err", err1, 0);
        chk("rst_mtip", mtip1, 0);
        chk("rst_msip", msip1, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // register access table
        vecs[0]  = mk(0, 0, A_MSIP, 4'h0, 32'h0, 32'h0, 0, 0);
        vecs[1]  = mk(1, 1, A_MSIP, 4'h1, 32'h1, 32'h0, 0, 1);
        vecs[2]  = mk(1, 0, A_MSIP, 4'h0, 32'h0, 32'h1, 0, 1);
        vecs[3]  = mk(1, 1, A_MSIP, 4'hE, 32'h0, 32'h0, 0, 1);
        vecs[4]  = mk(1, 0, A_MSIP, 4'h0, 32'h0, 32'h1, 0, 1);
        vecs[5]  = mk(1, 1, A_MSIP, 4'h1, 32'hFFFF_FFFE, 32'h0, 0, 0);
        vecs[6]  = mk(1, 1, A_MSIP, 4'hF, 32'hFFFF_FFFF, 32'h0, 0, 1);
        vecs[7]  = mk(1, 0, A_MSIP, 4'h0, 32'h0, 32'h1, 0, 1);
        vecs[8]  = mk(1, 1, A_MSIP, 4'h1, 32'h0, 32'h0, 0, 0);
        vecs[9]  = mk(1, 0, 16'h0008, 4'h0, 32'h0, 32'h0, 1, 0);
        vecs[10] = mk(1, 1, 16'h0008, 4'hF, 32'hFFFF_FFFF, 32'h0, 1, 0);
        vecs[11] = mk(1, 1, A_CLO, 4'hF, 32'hA5A5_1234, 32'h0, 0, 0);
        vecs[12] = mk(1, 0, A_CLO, 4'h0, 32'h0, 32'hA5A5_1234, 0, 0);
        vecs[13] = mk(1, 1, A_CHI, 4'h5, 32'h7777_8888, 32'h0, 0, 0);
        vecs[14] = mk(1, 0, A_CHI, 4'h0, 32'h0, 32'hFF77_FF88, 0, 0);
        vecs[15] = mk(1, 0, 16'h4002, 4'h0, 32'h0, 32'hA5A5_1234, 0, 0);
        vecs[16] = mk(1, 0, 16'h4008, 4'h0, 32'h0, 32'h0, 1, 0);
        vecs[17] = mk(1, 0, 16'hBFF4, 4'h0, 32'h0, 32'h0, 1, 0);
        vecs[18] = mk(1, 1, A_CHI, 4'hF, 32'hFFFF_FFFF, 32'h0, 0, 0);
        vecs[19] = mk(1, 1, A_CLO, 4'h0, 32'hFFFF_FFFF, 32'h0, 0, 0);
        vecs[20] = mk(1, 0, A_CLO, 4'h0, 32'h0, 32'hA5A5_1234, 0, 0);
        vecs[21] = mk(1, 1, A_CLO, 4'hF, 32'hFFFF_FFFF, 32'h0, 0, 0);
        vecs[22] = mk(1, 0, A_CHI, 4'h0, 32'h0, 32'hFFFF_FFFF, 0, 0);

        for (int i = 0; i < 23; i++) begin
            cyc(vecs[i].req, vecs[i].we, vecs[i].addr,
                vecs[i].be, vecs[i].wdata);
            chk($sformatf("vec%0d_rvalid", i), rvalid1, vecs[i].req);
            chk($sformatf("vec%0d_rdata", i), rdata1, vecs[i].exp_rdata);
            chk($sformatf("vec%0d_err", i), err1, vecs[i].exp_err);
            chk($sformatf("vec%0d_msip", i), msip1, vecs[i].exp_msip);
            chk($sformatf("vec%0d_mtip", i), mtip1, 0);
        end

        // one-cycle rvalid after an idle cycle
        cyc(0, 0, 16'h0, 4'h0, 32'h0);
        chk("idle_rvalid", rvalid1, 0);

        // carry lo -> hi
        wr(A_THI, 4'hF, 32'h0);
        wr(A_TLO, 4'hF, 32'hFFFF_FFFF);
        rd(A_TLO);
        chk("carry_lo_pre", rdata1, 32'hFFFF_FFFF);
        rd(A_TLO);
        chk("carry_lo_post", rdata1, 32'h0);
        rd(A_THI);
        chk("carry_hi_post", rdata1, 32'h1);

        // full 64-bit wrap; all-ones equals reset mtimecmp
        wr(A_THI, 4'hF, 32'hFFFF_FFFF);
        wr(A_TLO, 4'hF, 32'hFFFF_FFFF);
        chk("wrap_mtip_at_max", mtip1, 1);
        rd(A_TLO);
        chk("wrap_lo_pre", rdata1, 32'hFFFF_FFFF);
        chk("wrap_mtip_after", mtip1, 0);
        rd(A_THI);
        chk("wrap_hi_post", rdata1, 32'h0);
        rd(A_TLO);
        chk("wrap_lo_post", rdata1, 32'h1);

        // partial write on a tick cycle suppresses the increment
        wr(A_THI, 4'hF, 32'h0);
        wr(A_TLO, 4'hF, 32'hABCD_0000);
        wr(A_TLO, 4'h3, 32'h1234_5678);
        rd(A_TLO);
        chk("partial_lo", rdata1, 32'hABCD_5678);
        rd(A_TLO);
        chk("partial_lo_inc", rdata1, 32'hABCD_5679);
        rd(A_THI);
        chk("partial_hi", rdata1, 32'h0);

        // mtip rise against mtimecmp = 20
        wr(A_THI, 4'hF, 32'h0);
        wr(A_TLO, 4'hF, 32'h0);
        wr(A_CHI, 4'hF, 32'h0);
        wr(A_CLO, 4'hF, 32'd20);
        chk("mtip_armed_low", mtip1, 0);
        for (int i = 0; i < 25; i++) begin
            rd(A_TLO);
            chk($sformatf("mtip_cnt%0d", i), rdata1, 32'(2 + i));
            chk($sformatf("mtip_lvl%0d", i), mtip1, (2 + i) >= 19);
        end
        wr(A_CHI, 4'hF, 32'h1);
        chk("mtip_cmp_raised", mtip1, 0);
        wr(A_CHI, 4'hF, 32'h0);
        chk("mtip_cmp_lowered", mtip1, 1);
        wr(A_CLO, 4'hF, 32'hFFFF_FFFF);
        wr(A_CHI, 4'hF, 32'hFFFF_FFFF);
        chk("mtip_cmp_max", mtip1, 0);

        // prescaler 4: one increment per 4 cycles
        for (int i = 0; i < 40; i++) begin
            rd(A_TLO);
            vals[i] = rdata4;
        end
        for (int i = 0; i < 39; i++) begin
            chk($sformatf("div4_step%0d", i),
                (vals[i+1] - vals[i]) <= 32'd1, 1);
        end
        for (int i = 0; i < 36; i++) begin
            chk($sformatf("div4_period%0d", i), vals[i+4], vals[i] + 1);
        end

        // asynchronous reset with a response in flight
        wr(A_MSIP, 4'h1, 32'h1);
        wr(A_CHI, 4'hF, 32'h0);
        wr(A_CLO, 4'hF, 32'h0);
        chk("pre_rst_msip", msip1, 1);
        chk("pre_rst_mtip", mtip1, 1);
        bus_req = 1'b1; bus_we = 1'b0; bus_addr = A_CHI;
        #2;
        rst_n = 1'b0;
        #1;
        bus_req = 1'b0;
        chk("arst_rvalid", rvalid1, 0);
        chk("arst_rdata", rdata1, 0);
        chk("arst_err", err1, 0);
        chk("arst_mtip", mtip1, 0);
        chk("arst_msip", msip1, 0);
        chk("arst_rvalid4", rvalid4, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("arst_dropped", rvalid1, 0);
        @(negedge clk);
        rst_n = 1'b1;
        rd(A_CHI);
        chk("post_rst_cmp_hi", rdata1, 32'hFFFF_FFFF);
        chk("post_rst_mtip", mtip1, 0);
        rd(A_MSIP);
        chk("post_rst_msip", rdata1, 32'h0);
        chk("post_rst_mtip4", mtip4, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
